demux1x4_reg: RTL

DEMUX1X4_REG -- requirements
Module: demux1x4_reg

---
 rtl/demux1x4_reg.sv | 73 +++++++
 1 files changed

// File: rtl/demux1x4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready output slots.
// Optional build macro DEMUX_RR_EN replaces in_sel routing with a round-robin pointer.
module demux1x4_reg #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  input  logic [1:0]         in_sel,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [15:0]        xfer_cnt
);

  // Handshake: a word moves when valid & ready are both high at a rising edge;
  // valid never depends on ready, and ready here depends only on the addressed slot.
  logic [1:0] dest;
  logic       accept;
  logic [3:0] load;

`ifdef DEMUX_RR_EN
  logic [1:0] rr_ptr;
  logic       unused_sel;

  assign unused_sel = ^in_sel;
  assign dest       = rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 2'd0;
    end else if (accept) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end
`else
  assign dest = in_sel;
`endif

  // A full slot can still take a new word in the same cycle its sink drains it.
  assign in_ready = ~out_valid[dest] | out_ready[dest];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load       = 4'b0000;
    load[dest] = accept;
  end

  for (genvar k = 0; k < 4; k++) begin : g_chan
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid[k]                <= 1'b0;
        out_data[k*WIDTH +: WIDTH]  <= '0;
      end else if (load[k]) begin
        out_valid[k]                <= 1'b1;
        out_data[k*WIDTH +: WIDTH]  <= in_data;
      end else if (out_ready[k]) begin
        out_valid[k]                <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= 16'd0;
    end else if (accept) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule
